// File: rtl/sram_pipe_pkg.sv
// Shared types and width helpers for the sram_pipe controller.
package sram_pipe_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    localparam int unsigned CUT_WIDTH = 64;
    localparam int unsigned CUT_BYTES = CUT_WIDTH / 8;

    // Number of 64-bit cuts needed to hold a word of the given width.
    function automatic int unsigned cut_count(input int unsigned width);
        return (width + CUT_WIDTH - 1) / CUT_WIDTH;
    endfunction

    // Word width rounded up to a whole number of cuts.
    function automatic int unsigned aligned_width(input int unsigned width);
        return cut_count(width) * CUT_WIDTH;
    endfunction

    // Byte-enable width of the cut-aligned word.
    function automatic int unsigned aligned_be_width(input int unsigned width);
        return cut_count(width) * CUT_BYTES;
    endfunction

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_pipe_cut.sv
// One inferred memory cut: lane-enabled write, registered 1-cycle read.
// WIDTH/GRAN select the lane shape (64/8 for data, narrow/1 for parity).
module sram_pipe_cut #(
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned GRAN      = 8,
    parameter string       SIM_INIT  = "none",
    localparam int unsigned LANES    = WIDTH / GRAN,
    localparam int unsigned AW       = $clog2(NUM_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [LANES-1:0] be_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Simulation preload hook kept for flows that consume it; the array
    // itself carries no functional initial value.
    localparam string unused_sim_init = SIM_INIT;

    logic [WIDTH-1:0] r_mem [NUM_WORDS];
    logic [WIDTH-1:0] r_rdata;

    // Lane-enabled write into the array.
    // NOTE: the array has no reset; a reset would turn it into flops, and
    // deterministic contents come from the controller's zero-fill instead.
    // NOTE: sequential state always uses <= so every reader sees the
    // pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_i[i]) begin
                    r_mem[addr_i][i*GRAN +: GRAN] <= wdata_i[i*GRAN +: GRAN];
                end
            end
        end
    end

    // Read register: only reads update it, so it holds the last read word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (req_i && !we_i) begin
            r_rdata <= r_mem[addr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/sram_pipe.sv
// Byte-enabled single-port SRAM controller with req/gnt, post-reset zero
// fill, configurable read latency and optional user sideband.
// Optional byte parity: define SRAM_PIPE_PARITY_EN.
module sram_pipe
    import sram_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 0,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned OUT_REGS   = 0,
    parameter int unsigned INIT_ZERO  = 1,
    parameter string       SIM_INIT   = "none",
    localparam int unsigned AW = $clog2(NUM_WORDS),
    localparam int unsigned UW = (USER_WIDTH > 0) ? USER_WIDTH : 1,
    localparam int unsigned BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [UW-1:0]         wuser_i,
    input  logic [BW-1:0]         be_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [UW-1:0]         ruser_o,
    output logic                  init_done_o,
    output logic                  err_o
);

    localparam int unsigned NC     = cut_count(DATA_WIDTH);
    localparam int unsigned AL_DW  = aligned_width(DATA_WIDTH);
    localparam int unsigned AL_BW  = aligned_be_width(DATA_WIDTH);
    localparam int unsigned NUC    = cut_count(UW);
    localparam int unsigned AL_UW  = aligned_width(UW);
    localparam string CUT_SIM_INIT = (INIT_ZERO != 0) ? "none" : SIM_INIT;

    state_e           r_state;
    logic [AW-1:0]    r_init_cnt;
    logic             r_init_done;
    logic             w_init;
    logic             w_gnt;
    logic             w_in_range;
    logic             w_cut_req;
    logic             w_cut_we;
    logic [AW-1:0]    w_cut_addr;
    logic [AL_DW-1:0] w_cut_wdata;
    logic [AL_DW-1:0] w_cut_rdata;
    logic [AL_BW-1:0] w_cut_be;
    logic [UW-1:0]    w_user_rd;
    logic             w_par_err;
    logic             r_rd_v1;
    logic             r_oor1;

    assign w_init      = (r_state == ST_INIT);
    assign w_gnt       = req_i && (r_state == ST_IDLE);
    assign gnt_o       = w_gnt;
    assign init_done_o = r_init_done;

    // Non-power-of-two depths leave a tail of unbacked addresses.
    if ((1 << AW) == NUM_WORDS) begin : g_pow2
        assign w_in_range = 1'b1;
    end else begin : g_range
        assign w_in_range = ({1'b0, addr_i} < (AW+1)'(NUM_WORDS));
    end

    // Init/idle FSM: walk every address once, then hand over to requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
            r_init_cnt  <= '0;
            r_init_done <= (INIT_ZERO == 0);
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (r_init_cnt == AW'(NUM_WORDS - 1)) begin
                r_state     <= ST_IDLE;
                r_init_done <= 1'b1;
            end
        end
    end

    // Cut port mux: zero-fill writes during init, granted requests after.
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_cut_req   = 1'b0;
        w_cut_we    = 1'b0;
        w_cut_addr  = addr_i;
        w_cut_wdata = '0;
        w_cut_be    = '0;
        if (w_init) begin
            w_cut_req  = 1'b1;
            w_cut_we   = 1'b1;
            w_cut_addr = r_init_cnt;
            w_cut_be   = '1;
        end else begin
            w_cut_req   = w_gnt && w_in_range;
            w_cut_we    = we_i;
            w_cut_wdata = AL_DW'(wdata_i);
            w_cut_be    = AL_BW'(be_i);
        end
    end

    for (genvar c = 0; c < NC; c++) begin : g_data
        sram_pipe_cut #(
            .NUM_WORDS (NUM_WORDS),
            .WIDTH     (CUT_WIDTH),
            .GRAN      (8),
            .SIM_INIT  (CUT_SIM_INIT)
        ) u_cut (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .req_i   (w_cut_req),
            .we_i    (w_cut_we),
            .addr_i  (w_cut_addr),
            .wdata_i (w_cut_wdata[c*CUT_WIDTH +: CUT_WIDTH]),
            .be_i    (w_cut_be[c*CUT_BYTES +: CUT_BYTES]),
            .rdata_o (w_cut_rdata[c*CUT_WIDTH +: CUT_WIDTH])
        );
    end

    // Pad bits above DATA_WIDTH are stored as zero and never returned.
    logic unused_data_pad;
    assign unused_data_pad = ^w_cut_rdata;

    if (USER_WIDTH > 0) begin : g_user
        logic [AL_UW-1:0]   w_uwdata;
        logic [AL_UW-1:0]   w_urdata;
        logic [AL_UW/8-1:0] w_ube;
        logic               unused_user_pad;

        // The sideband follows the word: written whenever any byte is.
        assign w_uwdata = w_init ? '0 : AL_UW'(wuser_i);
        assign w_ube    = (w_init || (|be_i)) ? '1 : '0;

        for (genvar c = 0; c < NUC; c++) begin : g_ucut
            sram_pipe_cut #(
                .NUM_WORDS (NUM_WORDS),
                .WIDTH     (CUT_WIDTH),
                .GRAN      (8),
                .SIM_INIT  (CUT_SIM_INIT)
            ) u_cut (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .req_i   (w_cut_req),
                .we_i    (w_cut_we),
                .addr_i  (w_cut_addr),
                .wdata_i (w_uwdata[c*CUT_WIDTH +: CUT_WIDTH]),
                .be_i    (w_ube[c*CUT_BYTES +: CUT_BYTES]),
                .rdata_o (w_urdata[c*CUT_WIDTH +: CUT_WIDTH])
            );
        end

        assign w_user_rd       = w_urdata[UW-1:0];
        assign unused_user_pad = ^w_urdata;
    end else begin : g_no_user
        logic unused_wuser;
        assign unused_wuser = ^wuser_i;
        assign w_user_rd    = '0;
    end

`ifdef SRAM_PIPE_PARITY_EN
    logic [AL_BW-1:0] w_par_wdata;
    logic [AL_BW-1:0] w_par_rdata;
    logic             unused_par_pad;

    // Parity generation on the write word and checking on the read word.
    always_comb begin
        w_par_wdata = '0;
        w_par_err   = 1'b0;
        for (int i = 0; i < AL_BW; i++) begin
            w_par_wdata[i] = byte_parity(w_cut_wdata[i*8 +: 8]);
        end
        for (int i = 0; i < BW; i++) begin
            if (byte_parity(w_cut_rdata[i*8 +: 8]) != w_par_rdata[i]) begin
                w_par_err = 1'b1;
            end
        end
    end

    sram_pipe_cut #(
        .NUM_WORDS (NUM_WORDS),
        .WIDTH     (AL_BW),
        .GRAN      (1),
        .SIM_INIT  (CUT_SIM_INIT)
    ) u_par_cut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (w_cut_req),
        .we_i    (w_cut_we),
        .addr_i  (w_cut_addr),
        .wdata_i (w_par_wdata),
        .be_i    (w_cut_be),
        .rdata_o (w_par_rdata)
    );

    assign unused_par_pad = ^w_par_rdata;
`else
    assign w_par_err = 1'b0;
`endif

    // First read stage tracks which cut outputs carry a fresh, valid read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_v1 <= 1'b0;
            r_oor1  <= 1'b0;
        end else begin
            r_rd_v1 <= w_gnt && !we_i;
            if (w_gnt && !we_i) begin
                r_oor1 <= !w_in_range;
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_rdata1;
    logic [UW-1:0]         w_ruser1;
    logic                  w_err1;

    assign w_rdata1 = r_oor1 ? '0 : w_cut_rdata[DATA_WIDTH-1:0];
    assign w_ruser1 = r_oor1 ? '0 : w_user_rd;
    assign w_err1   = r_rd_v1 && !r_oor1 && w_par_err;

    if (OUT_REGS != 0) begin : g_out_reg
        logic                  r_rvalid;
        logic                  r_err;
        logic [DATA_WIDTH-1:0] r_rdata;
        logic [UW-1:0]         r_ruser;

        // Extra output stage; data only moves on a valid read so it holds.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rvalid <= 1'b0;
                r_err    <= 1'b0;
                r_rdata  <= '0;
                r_ruser  <= '0;
            end else begin
                r_rvalid <= r_rd_v1;
                r_err    <= w_err1;
                if (r_rd_v1) begin
                    r_rdata <= w_rdata1;
                    r_ruser <= w_ruser1;
                end
            end
        end

        assign rvalid_o = r_rvalid;
        assign err_o    = r_err;
        assign rdata_o  = r_rdata;
        assign ruser_o  = r_ruser;
    end else begin : g_out_direct
        assign rvalid_o = r_rd_v1;
        assign err_o    = w_err1;
        assign rdata_o  = w_rdata1;
        assign ruser_o  = w_ruser1;
    end

endmodule

// File: tb/tb_sram_pipe.sv
// Directed bench for sram_pipe. Two instances share one stimulus stream:
//   dut_a: 64-bit, 16 words, no sideband, latency 1
//   dut_b: 72-bit, 12 words (addresses 12..15 out of range), 4-bit user, latency 2
module tb_sram_pipe;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [71:0] wdata;
    logic [3:0]  wuser;
    logic [8:0]  be;

    logic        gnt_a, rvalid_a, init_done_a, err_a;
    logic [63:0] rdata_a;
    logic [0:0]  ruser_a;
    logic        gnt_b, rvalid_b, init_done_b, err_b;
    logic [71:0] rdata_b;
    logic [3:0]  ruser_b;

    int checks = 0;
    int errors = 0;

    sram_pipe #(
        .DATA_WIDTH (64), .USER_WIDTH (0), .NUM_WORDS (16),
        .OUT_REGS   (0),  .INIT_ZERO  (1), .SIM_INIT  ("none")
    ) dut_a (
        .clk_i (clk), .rst_ni (rst_n), .req_i (req), .gnt_o (gnt_a),
        .we_i (we), .addr_i (addr), .wdata_i (wdata[63:0]), .wuser_i (wuser[0]),
        .be_i (be[7:0]), .rvalid_o (rvalid_a), .rdata_o (rdata_a),
        .ruser_o (ruser_a), .init_done_o (init_done_a), .err_o (err_a)
    );

    sram_pipe #(
        .DATA_WIDTH (72), .USER_WIDTH (4), .NUM_WORDS (12),
        .OUT_REGS   (1),  .INIT_ZERO  (1), .SIM_INIT  ("none")
    ) dut_b (
        .clk_i (clk), .rst_ni (rst_n), .req_i (req), .gnt_o (gnt_b),
        .we_i (we), .addr_i (addr), .wdata_i (wdata), .wuser_i (wuser),
        .be_i (be), .rvalid_o (rvalid_b), .rdata_o (rdata_b),
        .ruser_o (ruser_b), .init_done_o (init_done_b), .err_o (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One request cycle; gnt is checked combinationally before the edge.
    task automatic drive(input logic r, input logic w, input logic [3:0] a,
                         input logic [71:0] d, input logic [3:0] u, input logic [8:0] b);
        req = r; we = w; addr = a; wdata = d; wuser = u; be = b;
        #1;
        check("gnt_a", gnt_a, r);
        check("gnt_b", gnt_b, r);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic write(input logic [3:0] a, input logic [71:0] d,
                         input logic [3:0] u, input logic [8:0] b);
        drive(1'b1, 1'b1, a, d, u, b);
        check("wr_no_rvalid_a", rvalid_a, 1'b0);
    endtask

    // Single read, then follow both latencies through to rvalid falling.
    task automatic read_check(input string tag, input logic [3:0] a, input logic [63:0] exp_a,
                              input logic [71:0] exp_b, input logic [3:0] exp_u,
                              input logic exp_err);
        drive(1'b1, 1'b0, a, '0, '0, '0);
        check({tag, "_rvalid_a"}, rvalid_a, 1'b1);
        check({tag, "_rdata_a"}, rdata_a, exp_a);
        check({tag, "_err_a"}, err_a, exp_err);
        check({tag, "_rvalid_b_early"}, rvalid_b, 1'b0);
        idle();
        check({tag, "_rvalid_a_drop"}, rvalid_a, 1'b0);
        check({tag, "_rvalid_b"}, rvalid_b, 1'b1);
        check({tag, "_rdata_b"}, rdata_b, exp_b);
        check({tag, "_ruser_b"}, ruser_b, exp_u);
        check({tag, "_err_b"}, err_b, exp_err);
        idle();
        check({tag, "_rvalid_b_drop"}, rvalid_b, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_gnt_a"}, gnt_a, 1'b0);
        check({tag, "_gnt_b"}, gnt_b, 1'b0);
        check({tag, "_rvalid_a"}, rvalid_a, 1'b0);
        check({tag, "_rvalid_b"}, rvalid_b, 1'b0);
        check({tag, "_rdata_a"}, rdata_a, 64'h0);
        check({tag, "_rdata_b"}, rdata_b, 72'h0);
        check({tag, "_ruser_a"}, ruser_a, 1'b0);
        check({tag, "_ruser_b"}, ruser_b, 4'h0);
        check({tag, "_done_a"}, init_done_a, 1'b0);
        check({tag, "_done_b"}, init_done_b, 1'b0);
        check({tag, "_err_a"}, err_a, 1'b0);
        check({tag, "_err_b"}, err_b, 1'b0);
    endtask

    // req held high from reset release: A inits 16 cycles, B 12 cycles.
    task automatic init_sweep(input string tag);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_done_a"}, init_done_a, k >= 16);
            check({tag, "_done_b"}, init_done_b, k >= 12);
            check({tag, "_gnt_a"}, gnt_a, k >= 16);
            check({tag, "_gnt_b"}, gnt_b, k >= 12);
            check({tag, "_rvalid_a"}, rvalid_a, k >= 17);
            check({tag, "_rvalid_b"}, rvalid_b, k >= 14);
        end
        req = 1'b0;
        repeat (3) idle();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        wuser = '0;
        be    = '0;

        // Reset values and first full initialisation.
        #12;
        reset_checks("rst");
        @(negedge clk);
        rst_n = 1'b1;
        init_sweep("init1");

        // Odd width with sideband; A sees the low 64 bits.
        write(4'd5, 72'hAB_0123_4567_89AB_CDEF, 4'h9, 9'h1FF);
        read_check("odd", 4'd5, 64'h0123_4567_89AB_CDEF, 72'hAB_0123_4567_89AB_CDEF, 4'h9, 1'b0);

        // Reset interrupting init at cycle 7 restarts the full sequence.
        @(negedge clk);
        req   = 1'b1;
        rst_n = 1'b0;
        #1;
        reset_checks("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) idle();
        check("mid_done_a", init_done_a, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt_a", gnt_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        init_sweep("init2");
        read_check("zeroed", 4'd5, 64'h0, 72'h0, 4'h0, 1'b0);

        // Byte enables, read directly after write, then an all-zero enable.
        write(4'd3, 72'hFF_FFFF_FFFF_FFFF_FFFF, 4'h5, 9'h1FF);
        write(4'd3, 72'h00_1122_3344_5566_7788, 4'h3, 9'h00F);
        read_check("be", 4'd3, 64'hFFFF_FFFF_5566_7788, 72'hFF_FFFF_FFFF_5566_7788, 4'h3, 1'b0);
        write(4'd3, 72'h0, 4'hA, 9'h000);
        read_check("be_none", 4'd3, 64'hFFFF_FFFF_5566_7788, 72'hFF_FFFF_FFFF_5566_7788, 4'h3, 1'b0);

        // Back-to-back reads fully pipelined.
        write(4'd0, 72'hA, 4'h1, 9'h1FF);
        write(4'd1, 72'hB, 4'h2, 9'h1FF);
        write(4'd2, 72'hC, 4'h3, 9'h1FF);
        drive(1'b1, 1'b0, 4'd0, '0, '0, '0);
        check("pipe0_rvalid_a", rvalid_a, 1'b1);
        check("pipe0_rdata_a", rdata_a, 64'hA);
        check("pipe0_rvalid_b", rvalid_b, 1'b0);
        drive(1'b1, 1'b0, 4'd1, '0, '0, '0);
        check("pipe1_rvalid_a", rvalid_a, 1'b1);
        check("pipe1_rdata_a", rdata_a, 64'hB);
        check("pipe1_rvalid_b", rvalid_b, 1'b1);
        check("pipe1_rdata_b", rdata_b, 72'hA);
        check("pipe1_ruser_b", ruser_b, 4'h1);
        drive(1'b1, 1'b0, 4'd2, '0, '0, '0);
        check("pipe2_rvalid_a", rvalid_a, 1'b1);
        check("pipe2_rdata_a", rdata_a, 64'hC);
        check("pipe2_rvalid_b", rvalid_b, 1'b1);
        check("pipe2_rdata_b", rdata_b, 72'hB);
        check("pipe2_ruser_b", ruser_b, 4'h2);
        idle();
        check("pipe3_rvalid_a", rvalid_a, 1'b0);
        check("pipe3_hold_a", rdata_a, 64'hC);
        check("pipe3_rvalid_b", rvalid_b, 1'b1);
        check("pipe3_rdata_b", rdata_b, 72'hC);
        check("pipe3_ruser_b", ruser_b, 4'h3);
        idle();
        check("pipe4_rvalid_b", rvalid_b, 1'b0);
        check("pipe4_hold_b", rdata_b, 72'hC);
        check("pipe4_hold_a", rdata_a, 64'hC);

        // Address 13 is beyond B's depth: write dropped, read returns 0.
        write(4'd13, 72'h66_5555_AAAA_5555_AAAA, 4'h7, 9'h1FF);
        write(4'd11, 72'h11_2233_4455_6677_8899, 4'h6, 9'h1FF);
        read_check("oor", 4'd13, 64'h5555_AAAA_5555_AAAA, 72'h0, 4'h0, 1'b0);
        check("oor_hold_b", rdata_b, 72'h0);
        read_check("last", 4'd11, 64'h2233_4455_6677_8899, 72'h11_2233_4455_6677_8899, 4'h6, 1'b0);

`ifdef SRAM_PIPE_PARITY_EN
        // Corrupt the stored parity of address 6 in both instances.
        write(4'd6, 72'h0, 4'h0, 9'h1FF);
        dut_a.u_par_cut.r_mem[6][0] = ~dut_a.u_par_cut.r_mem[6][0];
        dut_b.u_par_cut.r_mem[6][0] = ~dut_b.u_par_cut.r_mem[6][0];
        read_check("par_flip", 4'd6, 64'h0, 72'h0, 4'h0, 1'b1);
        read_check("par_clean", 4'd11, 64'h2233_4455_6677_8899, 72'h11_2233_4455_6677_8899, 4'h6, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_pipe.md
Name: sram_pipe

Overview:
- Single-port, byte-enabled SRAM controller built from 64-bit-aligned inferred memory cuts.
- Adds a req/gnt handshake and configurable read latency with an rvalid strobe.
- Carries an optional user sideband, stored alongside the data.
- Runs a hardware zero-initialisation sequence after reset.
- Replaces the plain wrapper in cache and scratchpad arrays that need deterministic post-reset contents and a valid-qualified read path.

Parameters:
- DATA_WIDTH, 64: data bits per word, any value >= 1.
- USER_WIDTH, 0: sideband bits per word; 0 removes the user array entirely.
- NUM_WORDS, 1024: depth, >= 2.
- OUT_REGS, 0: 0 gives read latency 1; 1 gives read latency 2 (extra output register).
- INIT_ZERO, 1: 1 zero-fills the array after reset; 0 grants immediately after reset.
- SIM_INIT, "none": simulation initialisation passed to the cuts; ignored when INIT_ZERO=1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  $clog2(NUM_WORDS)  word address.
- wdata_i  in  DATA_WIDTH  write data.
- wuser_i  in  max(USER_WIDTH,1)  write sideband.
- be_i  in  (DATA_WIDTH+7)/8  byte enables.
- rvalid_o  out  1  read data valid.
- rdata_o  out  DATA_WIDTH  read data.
- ruser_o  out  max(USER_WIDTH,1)  read sideband.
- init_done_o  out  1  initialisation complete.
- err_o  out  1  parity error; qualified by rvalid_o.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset values:
  - gnt_o=0, rvalid_o=0, rdata_o=0, ruser_o=0, err_o=0.
  - init_done_o=0 if INIT_ZERO=1, else 1.
- FSM states: INIT, IDLE.
  - INIT:
    - Internal counter walks addresses 0..NUM_WORDS-1, one word per cycle.
    - Each word is written all-zero with all byte enables set; user bits and parity are also zeroed.
    - gnt_o=0 throughout, and req_i is ignored.
    - After writing address NUM_WORDS-1, the FSM moves to IDLE the next cycle and init_done_o rises with it.
    - The sequence takes exactly NUM_WORDS cycles from reset deassertion.
  - IDLE:
    - gnt_o = req_i (combinational), so there is no backpressure once initialised.
    - A granted request is issued to the cuts in the same cycle.
- Reset asserted mid-INIT: the counter clears and INIT restarts from address 0 after release.
- Writes:
  - Only bytes with be_i[i]=1 are updated.
  - The user word is written whenever any be_i bit is set.
  - Writes produce no rvalid_o.
- Reads:
  - rvalid_o pulses exactly 1+OUT_REGS cycles after the granted read, one cycle per read.
  - Back-to-back reads are fully pipelined, one per cycle.
  - rdata_o/ruser_o hold the last read value until the next rvalid_o; they are not cleared between reads.
  - A read immediately following a write to the same address returns the newly written data.
- Width handling:
  - Data is padded to ceil(DATA_WIDTH/64) cuts of 64 bits.
  - Pad bits are written 0 and dropped on read.
  - Pad byte enables are tied 0.
- Out-of-range addresses (NUM_WORDS not a power of two): writes are dropped; reads return 0 with rvalid_o still asserted.

Optional Feature:
- Macro SRAM_PIPE_PARITY_EN.
- Defined:
  - One even-parity bit is stored per data byte, in an extra narrow cut, and updated under that byte's enable.
  - On read, parity is recomputed over the returned bytes.
  - err_o=1 in the rvalid_o cycle if any byte mismatches; err_o is pipelined with OUT_REGS.
- Undefined: no parity storage and err_o tied 0.

Decomposition:
- sram_pipe_pkg:
  - state enum (INIT, IDLE).
  - functions: aligned data width, aligned byte-enable width, cut count, byte parity.
- Sub-module sram_pipe_cut:
  - 64-bit wide, NUM_WORDS deep, byte-enabled.
  - 1-cycle read latency.
  - Instantiated per data cut, per user cut and for parity.

Test Plan:
- Init: NUM_WORDS=16, INIT_ZERO=1, req_i held high from reset → gnt_o=0 for 16 cycles, init_done_o rises at cycle 16, then read addr 5 → rdata_o=0.
- Byte enable: write addr 3 wdata=0xFFFF_FFFF_FFFF_FFFF be=0xFF, then write wdata=0x1122_3344_5566_7788 be=0x0F, read addr 3 → 0xFFFF_FFFF_5566_7788 after 1 cycle (OUT_REGS=0) or 2 cycles (OUT_REGS=1).
- Pipelined reads: read addrs 0,1,2 on consecutive cycles after writing 0xA,0xB,0xC → rvalid_o high for 3 consecutive cycles with 0xA,0xB,0xC in order; rdata_o holds 0xC afterwards.
- Odd width: DATA_WIDTH=72, USER_WIDTH=4, write 0xAB_0123456789ABCDEF with wuser=0x9, be all ones, read back → identical data, ruser_o=0x9.
- Reset mid-init: assert rst_ni at init cycle 7 → on release init_done_o stays 0 for a full NUM_WORDS cycles.
- Parity (SRAM_PIPE_PARITY_EN): write 0x00 to byte 0, force a bit flip in the cut via a bench hierarchical deposit, read → err_o=1 with rvalid_o; unflipped address → err_o=0.
